// File: rtl/bcd_clock_ctrl.sv
// Six-digit BCD time-of-day counter with prescaler, run/pause, validated load,
// 12/24-hour display, hh:mm alarm and day-rollover pulse. Time is held in 24-hour BCD.
module bcd_clock_ctrl #(
  parameter int CLK_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode12,
  input  logic       load,
  input  logic [3:0] ld_ms_hr,
  input  logic [3:0] ld_ls_hr,
  input  logic [3:0] ld_ms_min,
  input  logic [3:0] ld_ls_min,
  input  logic [3:0] ld_ms_sec,
  input  logic [3:0] ld_ls_sec,
  input  logic       alm_set,
  input  logic       alm_en,
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min,
  output logic [3:0] ms_sec,
  output logic [3:0] ls_sec,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_tick,
  output logic       alarm_hit,
  output logic       load_err
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic [3:0]    t_h1, t_h0, t_m1, t_m0, t_s1, t_s0;
  logic [3:0]    a_h1, a_h0, a_m1, a_m0;
  logic [3:0]    n_h1, n_h0, n_m1, n_m0, n_s1, n_s0;
  logic          sec_adv;
  logic          ld_ok;
  logic          al_ok;
  logic          roll;
  logic          hit;
  logic [6:0]    hr_bin;
  logic [6:0]    hr_d;

  assign sec_adv = run && (presc == PMAX);

  // Hour check rejects 24..29 as well as non-BCD digits.
  assign ld_ok = (ld_ms_hr <= 4'd2) && (ld_ls_hr <= 4'd9) &&
                 !((ld_ms_hr == 4'd2) && (ld_ls_hr > 4'd3)) &&
                 (ld_ms_min <= 4'd5) && (ld_ls_min <= 4'd9) &&
                 (ld_ms_sec <= 4'd5) && (ld_ls_sec <= 4'd9);

  assign al_ok = (ld_ms_hr <= 4'd2) && (ld_ls_hr <= 4'd9) &&
                 !((ld_ms_hr == 4'd2) && (ld_ls_hr > 4'd3)) &&
                 (ld_ms_min <= 4'd5) && (ld_ls_min <= 4'd9);

  always_comb begin
    n_h1 = t_h1;
    n_h0 = t_h0;
    n_m1 = t_m1;
    n_m0 = t_m0;
    n_s1 = t_s1;
    n_s0 = t_s0;
    if (t_s0 != 4'd9) begin
      n_s0 = t_s0 + 4'd1;
    end else begin
      n_s0 = 4'd0;
      if (t_s1 != 4'd5) begin
        n_s1 = t_s1 + 4'd1;
      end else begin
        n_s1 = 4'd0;
        if (t_m0 != 4'd9) begin
          n_m0 = t_m0 + 4'd1;
        end else begin
          n_m0 = 4'd0;
          if (t_m1 != 4'd5) begin
            n_m1 = t_m1 + 4'd1;
          end else begin
            n_m1 = 4'd0;
            if ((t_h1 == 4'd2) && (t_h0 == 4'd3)) begin
              n_h1 = 4'd0;
              n_h0 = 4'd0;
            end else if (t_h0 == 4'd9) begin
              n_h0 = 4'd0;
              n_h1 = t_h1 + 4'd1;
            end else begin
              n_h0 = t_h0 + 4'd1;
            end
          end
        end
      end
    end
  end

  assign roll = (t_h1 == 4'd2) && (t_h0 == 4'd3) && (t_m1 == 4'd5) &&
                (t_m0 == 4'd9) && (t_s1 == 4'd5) && (t_s0 == 4'd9);
  assign hit  = alm_en && (n_h1 == a_h1) && (n_h0 == a_h0) && (n_m1 == a_m1) &&
                (n_m0 == a_m0) && (n_s1 == 4'd0) && (n_s0 == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      t_h1      <= 4'd0;
      t_h0      <= 4'd0;
      t_m1      <= 4'd0;
      t_m0      <= 4'd0;
      t_s1      <= 4'd0;
      t_s0      <= 4'd0;
      a_h1      <= 4'd0;
      a_h0      <= 4'd0;
      a_m1      <= 4'd0;
      a_m0      <= 4'd0;
      sec_tick  <= 1'b0;
      day_tick  <= 1'b0;
      alarm_hit <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec_tick  <= 1'b0;
      day_tick  <= 1'b0;
      alarm_hit <= 1'b0;
      load_err  <= (load && !ld_ok) || (alm_set && !al_ok);
      // Any load strobe takes the cycle; a coincident second is dropped.
      if (load) begin
        if (ld_ok) begin
          t_h1  <= ld_ms_hr;
          t_h0  <= ld_ls_hr;
          t_m1  <= ld_ms_min;
          t_m0  <= ld_ls_min;
          t_s1  <= ld_ms_sec;
          t_s0  <= ld_ls_sec;
          presc <= '0;
        end
      end else if (run) begin
        if (sec_adv) begin
          presc     <= '0;
          t_h1      <= n_h1;
          t_h0      <= n_h0;
          t_m1      <= n_m1;
          t_m0      <= n_m0;
          t_s1      <= n_s1;
          t_s0      <= n_s0;
          sec_tick  <= 1'b1;
          day_tick  <= roll;
          alarm_hit <= hit;
        end else begin
          presc <= presc + PW'(1);
        end
      end
      if (alm_set && al_ok) begin
        a_h1 <= ld_ms_hr;
        a_h0 <= ld_ls_hr;
        a_m1 <= ld_ms_min;
        a_m0 <= ld_ls_min;
      end
    end
  end

  assign hr_bin = (7'(t_h1) * 7'd10) + 7'(t_h0);
  assign pm     = (hr_bin >= 7'd12);

  always_comb begin
    ms_hr  = t_h1;
    ls_hr  = t_h0;
    ms_min = t_m1;
    ls_min = t_m0;
    ms_sec = t_s1;
    ls_sec = t_s0;
    hr_d   = hr_bin - 7'd12;
    if (mode12) begin
      if (hr_bin == 7'd0) begin
        ms_hr = 4'd1;
        ls_hr = 4'd2;
      end else if (hr_bin > 7'd12) begin
        if (hr_d >= 7'd10) begin
          ms_hr = 4'd1;
          ls_hr = 4'(hr_d - 7'd10);
        end else begin
          ms_hr = 4'd0;
          ls_hr = 4'(hr_d);
        end
      end
    end
  end

endmodule

// File: doc/bcd_clock_ctrl.md
Name: bcd_clock_ctrl

Overview:
Parametrised successor to the team's six-digit BCD time-of-day counter. Adds a clock prescaler, run/pause control, validated time load, 12/24-hour display mode, an hh:mm alarm and a day-rollover pulse. Sits between the board oscillator and the seven-segment display driver. Internal time is always kept in 24-hour BCD.

Parameters:
CLK_PER_SEC, 1, clk cycles per one-second tick (>=1); prescaler width is $clog2(CLK_PER_SEC), minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
run  in  1  1 = count seconds; 0 = freeze time and prescaler
mode12  in  1  1 = 12-hour display, 0 = 24-hour display
load  in  1  one-cycle strobe; load time from ld_* inputs
ld_ms_hr, ld_ls_hr, ld_ms_min, ld_ls_min, ld_ms_sec, ld_ls_sec  in  4 each  BCD load value, 24-hour format
alm_set  in  1  one-cycle strobe; capture ld_ms_hr, ld_ls_hr, ld_ms_min, ld_ls_min as the alarm time
alm_en  in  1  alarm enable
ms_hr, ls_hr, ms_min, ls_min, ms_sec, ls_sec  out  4 each  displayed BCD time
pm  out  1  1 when internal hour >= 12 (valid in both modes)
sec_tick  out  1  one-cycle pulse on each second advance
day_tick  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
alarm_hit  out  1  one-cycle alarm pulse
load_err  out  1  one-cycle pulse when a load or alm_set value is rejected

Behaviour:
- Reset: internal time 00:00:00, prescaler 0, alarm register 00:00, all pulse outputs 0. Display after reset is 00:00:00 in 24-hour mode, or 12:00:00 with pm=0 in 12-hour mode.
- Prescaler: counts 0..CLK_PER_SEC-1 while run=1 and holds while run=0. Internal sec_adv is true when the prescaler = CLK_PER_SEC-1 and run=1; the prescaler then wraps to 0.
- With CLK_PER_SEC=1: time advances every clock cycle while run=1.
- Seconds advance on sec_adv:
  - ls_sec wraps 9->0 and carries to ms_sec.
  - ms_sec wraps 5->0 and carries to minutes.
  - Minutes wrap the same way and carry to hours.
  - Hours count 00..23 and wrap to 00: ls_hr wraps 9->0, except 23 -> 00.
- Time registers update on the clock edge where sec_adv is true.
- Registered pulses, each high for exactly the following one cycle:
  - sec_tick: on every sec_adv.
  - day_tick: on the rollover from 23:59:59 to 00:00:00.
  - alarm_hit: when alm_en=1 and the new time equals alarm hh:mm:00.
- Load:
  - Valid when every digit is <= 9, the hour is <= 23, and ms_min and ms_sec are <= 5.
  - Valid load: the time takes the ld_* value on the next edge, and the prescaler clears to 0.
  - Invalid load: time and prescaler unchanged; load_err pulses for one cycle.
  - Load wins over sec_adv in the same cycle; that tick is dropped and sec_tick stays 0.
  - A load never raises alarm_hit or day_tick, even when the loaded time matches.
- alm_set: validates hour <= 23, ms_min <= 5 and all digits <= 9. A valid value is captured; an invalid one pulses load_err and leaves the alarm unchanged. load and alm_set together are independent; load_err pulses if either is invalid.
- Display conversion (combinational from internal time):
  - mode12=0: outputs equal the internal time.
  - mode12=1: hour 0 -> 12; hours 13..23 -> hour-12, BCD-correct (e.g. 13 -> 01, 22 -> 10); 1..12 unchanged.
  - Minutes and seconds pass through in both modes.
  - mode12 may change at any time and affects only the display.
- rst asserted at any point (mid-count, during load) forces the reset state on the next edge. rst overrides load, alm_set and run.

Test Plan:
1. CLK_PER_SEC=4, rst then run=1 for 16 cycles -> time 00:00:04; sec_tick high once every 4 cycles.
2. Load 23:59:58 with run=1 -> after 2 seconds, time 00:00:00; day_tick pulses once in the cycle after the rollover edge.
3. Load 13:05:00, then toggle mode12 -> display 13:05:00 with pm=1 when mode12=0, and 01:05:00 with pm=1 when mode12=1. Internal 00:30:00 with mode12=1 -> 12:30:00, pm=0.
4. Load 24:00:00, then 12:60:00, then 09:0A:00 -> each rejected; load_err pulses; time unchanged.
5. alm_set 07:00, alm_en=1, load 06:59:59 -> alarm_hit pulses exactly once after the next second. Repeat with alm_en=0 -> no pulse. Load 07:00:00 directly -> no pulse.
6. Freeze and reset mid-operation:
   - run=0 for 10 cycles mid-second -> time and prescaler frozen; resuming completes the second with the remaining prescaler count.
   - rst asserted together with load -> 00:00:00, no load_err.
